jtag_user_dr: RTL and testbench
===============================

Name: jtag_user_dr

Overview:
- Instruction-register and user data-register stage fed directly by the JTAG TAP controller's decoded state strobes (TLRESET, CAP_DR, SHFT_DR, SHFT_IR, UPDT_DR, UPDT_IR).
- Holds the IR and decodes the instruction.
- Captures, shifts and updates the selected data register (bypass, write register, read-status register).
- Drives TDO back to the JTAG chain, and presents the parallel write register plus an update strobe to DCFEB/ODMB core logic.

Parameters:
IR_LEN, 4, instruction register width
DR_LEN, 16, user data register width
CMD_WR, 4'h2, opcode selecting writable user register
CMD_RD, 4'h3, opcode selecting read-only STATUS capture
IR_RST, 4'hF, INSTR value on reset/TLRESET (BYPASS)
IDCODE_VAL, 32'h0000_0001, IDCODE value (used only with optional feature)

Ports:
TCK  in  1  JTAG clock; all state on rising edge
TRST_N  in  1  synchronous active-low reset, sampled on TCK rising edge
TDI  in  1  serial data in
TLRESET  in  1  TAP strobe: Test_Logic_Reset
CAP_DR  in  1  TAP strobe: Capture_DR
SHFT_DR  in  1  TAP strobe: Shift_DR
SHFT_IR  in  1  TAP strobe: Shift_IR
UPDT_DR  in  1  TAP strobe: Update_DR
UPDT_IR  in  1  TAP strobe: Update_IR
STATUS  in  DR_LEN  parallel status captured under CMD_RD
TDO  out  1  serial data out
INSTR  out  IR_LEN  current instruction
DR_Q  out  DR_LEN  parallel user register (CMD_WR)
DR_STB  out  1  one-TCK pulse on DR_Q update

Behaviour:
- One clock, TCK. Reset is synchronous and active-low: TRST_N, sampled on the TCK rising edge.
- Strobe timing: each strobe is high during the TCK cycle spent in its TAP state. An action occurs on the rising edge at which its strobe is sampled high.
- Strobe priority if more than one is high: TLRESET > UPDT_IR > UPDT_DR > CAP_DR > SHFT_IR > SHFT_DR. Lower-priority strobes are ignored that edge.
- Reset (TRST_N=0):
  - INSTR=IR_RST; IR shift reg = capture pattern {0..0,01}.
  - DR_Q=0; DR shift reg=0; bypass bit=0; DR_STB=0.
  - Reset mid-scan aborts the scan; no update occurs.
- TLRESET: INSTR=IR_RST and IR shift reg = capture pattern. DR_Q is retained. DR_STB=0.
- IR path:
  - SHFT_IR: ir_sr <= {TDI, ir_sr[IR_LEN-1:1]} (LSB first).
  - UPDT_IR: INSTR <= ir_sr, and ir_sr reloads the capture pattern in the same edge. The next IR scan therefore shifts out ...01 first.
- DR select: CMD_WR → write reg; CMD_RD → status reg; any other opcode → 1-bit bypass.
- CAP_DR:
  - Bypass bit <= 0.
  - dr_sr <= DR_Q (CMD_WR) or STATUS (CMD_RD).
- SHFT_DR:
  - Selected register shifts LSB first, TDI entering the MSB.
  - Bypass: bit <= TDI.
- UPDT_DR:
  - If INSTR==CMD_WR: DR_Q <= dr_sr on that edge, and DR_STB=1 for exactly the following TCK cycle.
  - Otherwise: no effect, DR_STB stays 0.
- DR_STB: deasserts on the next edge unconditionally. Back-to-back updates produce separate pulses.
- TDO: combinational mux of register LSBs only (no logic from TDI).
  - SHFT_IR high: ir_sr[0].
  - Otherwise: LSB of the selected DR (bypass bit, or dr_sr[0]).
- Shift count is not checked:
  - Fewer than DR_LEN shifts leave partially shifted content; UPDT_DR loads it as-is.
  - Extra shifts wrap TDI through and drop the LSBs.

Optional Feature:
JTAG_USER_DR_IDCODE_EN
- Defined:
  - Adds a 32-bit IDCODE register selected by opcode IR_RST.
  - CAP_DR loads IDCODE_VAL; it shifts like other DRs; UPDT_DR has no effect.
  - After reset or TLRESET, a DR scan returns IDCODE_VAL LSB first.
  - Bypass remains for all other unlisted opcodes.
- Undefined: IR_RST selects bypass; no IDCODE logic is present.

Test Plan:
- TRST_N=0 for 2 TCK → INSTR=4'hF, DR_Q=0, DR_STB=0. Then CAP_DR plus 3 SHFT_DR with TDI=1,1,0 → TDO=0,1,1 (bypass delay of 1).
- SHFT_IR ×4 with TDI=0,1,0,0 then UPDT_IR → INSTR=4'h2. TDO during those shifts=1,0,0,0.
- With INSTR=2: CAP_DR, then 16 SHFT_DR shifting 0xA5C3 LSB first, then UPDT_DR.
  - TDO streams the old DR_Q=0x0000.
  - DR_Q=0xA5C3 with DR_STB high exactly 1 cycle.
  - A repeat scan returns 0xA5C3 on TDO.
- INSTR=3, STATUS=0x1234: CAP_DR plus 16 SHFT_DR → TDO emits 0x1234 LSB first. UPDT_DR leaves DR_Q unchanged and DR_STB=0.
- Mid-scan TRST_N=0 after 8 shifts under CMD_WR → no DR_STB, DR_Q=0, INSTR=4'hF. TLRESET alone with DR_Q=0xA5C3 → INSTR=4'hF, DR_Q retained.
- TLRESET and UPDT_DR high together → TLRESET wins: no DR_STB, INSTR=IR_RST. With JTAG_USER_DR_IDCODE_EN, a following 32-shift DR scan returns 0x00000001.

Source files
------------

// File: rtl/jtag_user_dr_if.sv
// Bundle between the TAP controller/core and the user DR stage: strobes, serial data, parallel regs.
// Latency: none, the bundle is wires only; timing is owned by the connected modules.
// Backpressure: none; JTAG strobes are fire-and-forget and the core must accept DR_STB when it pulses.
interface jtag_user_dr_if #(
    parameter int IR_LEN = 4,
    parameter int DR_LEN = 16
) ();
    // TAP side to DR stage
    logic              TDI;
    logic              TLRESET;
    logic              CAP_DR;
    logic              SHFT_DR;
    logic              SHFT_IR;
    logic              UPDT_DR;
    logic              UPDT_IR;
    // Core status into the read register
    logic [DR_LEN-1:0] STATUS;
    // DR stage back to the chain and the core
    logic              TDO;
    logic [IR_LEN-1:0] INSTR;
    logic [DR_LEN-1:0] DR_Q;
    logic              DR_STB;

    // Driver of strobes/status (TAP controller plus core, or a testbench)
    modport master (
        output TDI, TLRESET, CAP_DR, SHFT_DR, SHFT_IR, UPDT_DR, UPDT_IR, STATUS,
        input  TDO, INSTR, DR_Q, DR_STB
    );

    // The IR/DR stage itself
    modport slave (
        input  TDI, TLRESET, CAP_DR, SHFT_DR, SHFT_IR, UPDT_DR, UPDT_IR, STATUS,
        output TDO, INSTR, DR_Q, DR_STB
    );
endinterface

// File: rtl/jtag_user_dr.sv
// JTAG IR plus user DRs (bypass, write reg, status read); optional IDCODE via JTAG_USER_DR_IDCODE_EN.
// Latency: each strobe acts on the TCK edge it is sampled at; DR_Q/INSTR registered, TDO combinational.
// Backpressure: none; the TAP dictates every cycle, DR_STB is a single-cycle pulse the core must take.
module jtag_user_dr #(
    parameter int                IR_LEN     = 4,
    parameter int                DR_LEN     = 16,
    parameter logic [IR_LEN-1:0] CMD_WR     = 'h2,
    parameter logic [IR_LEN-1:0] CMD_RD     = 'h3,
    parameter logic [IR_LEN-1:0] IR_RST     = 'hF
`ifdef JTAG_USER_DR_IDCODE_EN
    ,
    parameter logic [31:0]       IDCODE_VAL = 32'h0000_0001
`endif
) (
    input  logic          TCK,
    input  logic          TRST_N,
    jtag_user_dr_if.slave bus
);

    // Pattern loaded into the IR shifter on reset and every Update_IR;
    // the mandatory "...01" lets the chain verify IR length on the next scan.
    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IR_LEN-1:0] r_instr;
    logic [IR_LEN-1:0] r_ir_sr;
    logic [DR_LEN-1:0] r_dr_sr;     // shared shifter for write and status registers
    logic [DR_LEN-1:0] r_dr_q;
    logic              r_dr_stb;
    logic              r_bypass;
`ifdef JTAG_USER_DR_IDCODE_EN
    logic [31:0]       r_idcode_sr;
`endif

    // ------------------------------------------------------------------
    // Strobe arbitration: at most one action per edge
    // ------------------------------------------------------------------
    logic w_do_tlr;
    logic w_do_uir;
    logic w_do_udr;
    logic w_do_cdr;
    logic w_do_sir;
    logic w_do_sdr;

    // Fixed priority TLRESET > UPDT_IR > UPDT_DR > CAP_DR > SHFT_IR > SHFT_DR
    always_comb begin
        w_do_tlr = 1'b0;
        w_do_uir = 1'b0;
        w_do_udr = 1'b0;
        w_do_cdr = 1'b0;
        w_do_sir = 1'b0;
        w_do_sdr = 1'b0;
        if (bus.TLRESET)      w_do_tlr = 1'b1;
        else if (bus.UPDT_IR) w_do_uir = 1'b1;
        else if (bus.UPDT_DR) w_do_udr = 1'b1;
        else if (bus.CAP_DR)  w_do_cdr = 1'b1;
        else if (bus.SHFT_IR) w_do_sir = 1'b1;
        else if (bus.SHFT_DR) w_do_sdr = 1'b1;
    end

    // ------------------------------------------------------------------
    // Instruction decode: which DR sits between TDI and TDO
    // ------------------------------------------------------------------
    logic w_sel_wr;
    logic w_sel_rd;
    logic w_sel_sr;      // either register that lives in r_dr_sr
`ifdef JTAG_USER_DR_IDCODE_EN
    logic w_sel_id;
`endif

    // Decode the held instruction; unlisted opcodes fall through to bypass
    always_comb begin
        w_sel_wr = (r_instr == CMD_WR);
        w_sel_rd = (r_instr == CMD_RD);
        w_sel_sr = w_sel_wr | w_sel_rd;
`ifdef JTAG_USER_DR_IDCODE_EN
        w_sel_id = (r_instr == IR_RST);
`endif
    end

    // ------------------------------------------------------------------
    // IR path
    // ------------------------------------------------------------------
    // Instruction shifter and held instruction; TLRESET forces the reset opcode
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            r_instr <= IR_RST;
            r_ir_sr <= IR_CAPTURE;
        end else if (w_do_tlr) begin
            r_instr <= IR_RST;
            r_ir_sr <= IR_CAPTURE;
        end else if (w_do_uir) begin
            r_instr <= r_ir_sr;
            r_ir_sr <= IR_CAPTURE;
        end else if (w_do_sir) begin
            r_ir_sr <= {bus.TDI, r_ir_sr[IR_LEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // DR shift path
    // ------------------------------------------------------------------
    // Capture then shift LSB first into whichever DR is selected; shift count is not policed
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            r_dr_sr  <= '0;
            r_bypass <= 1'b0;
        end else if (w_do_cdr) begin
            r_bypass <= 1'b0;
            if (w_sel_wr)
                r_dr_sr <= r_dr_q;
            else if (w_sel_rd)
                r_dr_sr <= bus.STATUS;
        end else if (w_do_sdr) begin
            if (w_sel_sr)
                r_dr_sr <= {bus.TDI, r_dr_sr[DR_LEN-1:1]};
`ifdef JTAG_USER_DR_IDCODE_EN
            else if (w_sel_id)
                r_dr_sr <= r_dr_sr;
`endif
            else
                r_bypass <= bus.TDI;
        end
    end

`ifdef JTAG_USER_DR_IDCODE_EN
    // IDCODE register: reloaded on every capture so each scan starts from the fixed value
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            r_idcode_sr <= IDCODE_VAL;
        end else if (w_do_cdr && w_sel_id) begin
            r_idcode_sr <= IDCODE_VAL;
        end else if (w_do_sdr && w_sel_id) begin
            r_idcode_sr <= {bus.TDI, r_idcode_sr[31:1]};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Parallel update to the core
    // ------------------------------------------------------------------
    // Write register commits only under CMD_WR; the strobe lasts exactly one TCK
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            r_dr_q   <= '0;
            r_dr_stb <= 1'b0;
        end else begin
            r_dr_stb <= 1'b0;
            if (w_do_udr && w_sel_wr) begin
                r_dr_q   <= r_dr_sr;
                r_dr_stb <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serial output
    // ------------------------------------------------------------------
    logic w_tdo;

    // TDO is a pure mux of register LSBs so there is never a TDI-to-TDO path
    always_comb begin
        w_tdo = r_bypass;
        if (bus.SHFT_IR)
            w_tdo = r_ir_sr[0];
        else if (w_sel_sr)
            w_tdo = r_dr_sr[0];
`ifdef JTAG_USER_DR_IDCODE_EN
        else if (w_sel_id)
            w_tdo = r_idcode_sr[0];
`endif
    end

    assign bus.TDO    = w_tdo;
    assign bus.INSTR  = r_instr;
    assign bus.DR_Q   = r_dr_q;
    assign bus.DR_STB = r_dr_stb;

endmodule

// File: tb/tb_jtag_user_dr.sv
// Directed bench for jtag_user_dr: IR/DR scans, update strobe, resets and strobe priority.
// Latency: inputs change 1 time unit after each TCK rise; outputs sampled before the next rise.
// Backpressure: none; the bench plays the TAP controller cycle by cycle.
module tb_jtag_user_dr;

    logic TCK    = 1'b0;
    logic TRST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Strobe vectors: {TLRESET, UPDT_IR, UPDT_DR, CAP_DR, SHFT_IR, SHFT_DR}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_TLR  = 6'b100000;
    localparam logic [5:0] S_UIR  = 6'b010000;
    localparam logic [5:0] S_UDR  = 6'b001000;
    localparam logic [5:0] S_CDR  = 6'b000100;
    localparam logic [5:0] S_SIR  = 6'b000010;
    localparam logic [5:0] S_SDR  = 6'b000001;

    jtag_user_dr_if #(.IR_LEN(4), .DR_LEN(16)) bus ();

    jtag_user_dr dut (
        .TCK    (TCK),
        .TRST_N (TRST_N),
        .bus    (bus)
    );

    always #5 TCK = ~TCK;

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_str(input logic [5:0] s);
        {bus.TLRESET, bus.UPDT_IR, bus.UPDT_DR, bus.CAP_DR, bus.SHFT_IR, bus.SHFT_DR} = s;
    endtask

    task automatic pulse(input logic [5:0] s);
        set_str(s);
        tick();
        set_str(S_NONE);
    endtask

    // n Shift_DR cycles; TDO checked each cycle against exp[i]
    task automatic shift_dr(input logic [31:0] din, input int n, input logic [31:0] exp,
                            input string tag);
        for (int i = 0; i < n; i++) begin
            bus.TDI = din[i];
            set_str(S_SDR);
            #1;
            check(tag, {31'b0, bus.TDO}, {31'b0, exp[i]});
            tick();
        end
        set_str(S_NONE);
        bus.TDI = 1'b0;
    endtask

    // Full IR scan: 4 shifts with TDO checks, then Update_IR
    task automatic scan_ir(input logic [3:0] din, input logic [3:0] exp, input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.TDI = din[i];
            set_str(S_SIR);
            #1;
            check(tag, {31'b0, bus.TDO}, {31'b0, exp[i]});
            tick();
        end
        bus.TDI = 1'b0;
        pulse(S_UIR);
    endtask

    initial begin
        bus.TDI    = 1'b0;
        bus.STATUS = 16'h0000;
        set_str(S_NONE);

        // Reset held for two edges
        TRST_N = 1'b0;
        tick();
        tick();
        check("rst_instr",  {28'b0, bus.INSTR}, 32'hF);
        check("rst_dr_q",   {16'b0, bus.DR_Q},  32'h0);
        check("rst_dr_stb", {31'b0, bus.DR_STB}, 32'h0);
        TRST_N = 1'b1;

        // Default DR after reset: TDI 1,1,0
        pulse(S_CDR);
`ifdef JTAG_USER_DR_IDCODE_EN
        shift_dr(32'b011, 3, 32'b001, "idcode_first_bits");
`else
        shift_dr(32'b011, 3, 32'b110, "bypass_tdo");
`endif

        // IR scan TDI 0,1,0,0 -> CMD_WR; capture pattern shifts out 1,0,0,0
        scan_ir(4'b0010, 4'b0001, "ir_tdo_wr");
        check("instr_wr", {28'b0, bus.INSTR}, 32'h2);

        // Write scan: old DR_Q (0) streams out, 0xA5C3 goes in
        pulse(S_CDR);
        shift_dr(32'h0000_A5C3, 16, 32'h0, "wr_tdo_old");
        pulse(S_UDR);
        check("wr_dr_q",     {16'b0, bus.DR_Q},   32'hA5C3);
        check("wr_stb_high", {31'b0, bus.DR_STB}, 32'h1);
        tick();
        check("wr_stb_low",  {31'b0, bus.DR_STB}, 32'h0);

        // Repeat scan reads back the written value
        pulse(S_CDR);
        shift_dr(32'h0, 16, 32'h0000_A5C3, "wr_readback");

        // Status read: TDI 1,1,0,0 -> CMD_RD
        scan_ir(4'b0011, 4'b0001, "ir_tdo_rd");
        check("instr_rd", {28'b0, bus.INSTR}, 32'h3);
        bus.STATUS = 16'h1234;
        pulse(S_CDR);
        shift_dr(32'h0000_FFFF, 16, 32'h0000_1234, "status_tdo");
        pulse(S_UDR);
        check("rd_dr_q_kept", {16'b0, bus.DR_Q},   32'hA5C3);
        check("rd_no_stb",    {31'b0, bus.DR_STB}, 32'h0);

        // Reset in the middle of a write scan
        scan_ir(4'b0010, 4'b0001, "ir_tdo_wr2");
        pulse(S_CDR);
        shift_dr(32'h0000_FFFF, 8, 32'h0000_00C3, "midscan_tdo");
        TRST_N = 1'b0;
        tick();
        TRST_N = 1'b1;
        check("midrst_stb",   {31'b0, bus.DR_STB}, 32'h0);
        check("midrst_dr_q",  {16'b0, bus.DR_Q},   32'h0);
        check("midrst_instr", {28'b0, bus.INSTR},  32'hF);
        pulse(S_UDR);
        check("midrst_udr_stb",  {31'b0, bus.DR_STB}, 32'h0);
        check("midrst_udr_dr_q", {16'b0, bus.DR_Q},   32'h0);

        // TLRESET keeps DR_Q
        scan_ir(4'b0010, 4'b0001, "ir_tdo_wr3");
        pulse(S_CDR);
        shift_dr(32'h0000_A5C3, 16, 32'h0, "rewrite_tdo");
        pulse(S_UDR);
        check("rewrite_dr_q", {16'b0, bus.DR_Q},   32'hA5C3);
        check("rewrite_stb",  {31'b0, bus.DR_STB}, 32'h1);
        pulse(S_TLR);
        check("tlr_instr", {28'b0, bus.INSTR},  32'hF);
        check("tlr_dr_q",  {16'b0, bus.DR_Q},   32'hA5C3);
        check("tlr_stb",   {31'b0, bus.DR_STB}, 32'h0);

        // TLRESET and UPDT_DR together: reset wins, no update
        scan_ir(4'b0010, 4'b0001, "ir_tdo_wr4");
        pulse(S_CDR);
        shift_dr(32'h0000_1111, 16, 32'h0000_A5C3, "prio_tdo");
        pulse(S_TLR | S_UDR);
        check("prio_stb",   {31'b0, bus.DR_STB}, 32'h0);
        check("prio_instr", {28'b0, bus.INSTR},  32'hF);
        check("prio_dr_q",  {16'b0, bus.DR_Q},   32'hA5C3);

        // DR scan after TLRESET
        pulse(S_CDR);
`ifdef JTAG_USER_DR_IDCODE_EN
        shift_dr(32'h0, 32, 32'h0000_0001, "idcode_tdo");
`else
        shift_dr(32'b01, 2, 32'b10, "post_tlr_bypass");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
